// File: rtl/med_ctrl_if.sv
// Control handshake between the pixel source, the median sequencer and the MED datapath.
// The master side drives the load strobe; the slave side is the sequencer.
interface med_ctrl_if;
  logic DSI;
  logic BYP;
  logic DSO;
  logic BUSY;

  modport master (
    output DSI,
    input  BYP,
    input  DSO,
    input  BUSY
  );

  modport slave (
    input  DSI,
    output BYP,
    output DSO,
    output BUSY
  );
endinterface

// File: rtl/med_ctrl.sv
// Sequencer for the MED median datapath: counts N pixel loads, then walks the
// compare/rotate schedule that bubbles the median into the tail register.
module med_ctrl #(
  parameter int unsigned N = 9
) (
  input  logic     CLK,
  input  logic     nRST,
  med_ctrl_if.slave bus
);

  localparam int unsigned CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST_LOAD = CW'(N - 1);
  localparam logic [CW-1:0] LAST_PASS = CW'((N - 1) / 2);
  localparam logic [CW-1:0] CMP_BASE  = CW'(N - 2);
  localparam logic [CW-1:0] ONE       = CW'(1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CMP  = 3'd2,
    ROT  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] l_cnt, l_nx;
  logic [CW-1:0] p_cnt, p_nx;
  logic [CW-1:0] s_cnt, s_nx;
  logic [CW-1:0] cmp_last;
  logic          byp_nx, dso_nx, busy_nx;

  // Compare pass P spans N-1-P cycles, so its last step index is N-2-P.
  assign cmp_last = CMP_BASE - p_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      l_cnt    <= '0;
      p_cnt    <= '0;
      s_cnt    <= '0;
      bus.BYP  <= 1'b1;
      bus.DSO  <= 1'b0;
      bus.BUSY <= 1'b0;
    end else begin
      state    <= state_nx;
      l_cnt    <= l_nx;
      p_cnt    <= p_nx;
      s_cnt    <= s_nx;
      bus.BYP  <= byp_nx;
      bus.DSO  <= dso_nx;
      bus.BUSY <= busy_nx;
    end
  end

  always_comb begin
    state_nx = state;
    l_nx     = l_cnt;
    p_nx     = p_cnt;
    s_nx     = s_cnt;

    unique case (state)
      IDLE, DONE: begin
        if (bus.DSI) begin
          l_nx     = ONE;
          s_nx     = '0;
          state_nx = LOAD;
        end else begin
          state_nx = IDLE;
        end
      end

      LOAD: begin
        if (bus.DSI) begin
          if (l_cnt == LAST_LOAD) begin
            l_nx     = '0;
            p_nx     = '0;
            s_nx     = '0;
            state_nx = CMP;
          end else begin
            l_nx = l_cnt + ONE;
          end
        end
      end

      CMP: begin
        if (s_cnt == cmp_last) begin
          s_nx     = '0;
          state_nx = (p_cnt == LAST_PASS) ? DONE : ROT;
        end else begin
          s_nx = s_cnt + ONE;
        end
      end

      ROT: begin
        if (s_cnt == p_cnt) begin
          s_nx     = '0;
          p_nx     = p_cnt + ONE;
          state_nx = CMP;
        end else begin
          s_nx = s_cnt + ONE;
        end
      end

      default: begin
        state_nx = IDLE;
        l_nx     = '0;
        p_nx     = '0;
        s_nx     = '0;
      end
    endcase

    // Outputs are a Moore decode of the next state, registered alongside it.
    byp_nx  = (state_nx != CMP);
    busy_nx = (state_nx == CMP) || (state_nx == ROT);
    dso_nx  = (state_nx == DONE);
  end

endmodule

// File: doc/med_ctrl.md
# med_ctrl

Sequencer for the median datapath (MED, nine-register shift chain with one MCE comparator at its tail). It counts the pixel-load strobe from upstream, then drives the datapath's bypass select through the fixed compare/rotate schedule that bubbles the median into the output register. It flags the single cycle on which DO carries the median. It sits between the pixel source and MED; MED's DSI is driven by the same upstream DSI wire, and MED's BYP is driven by this block.

## Interface
- number, 9, window size N; odd, 3 ≤ N ≤ 15; internal counters sized $clog2(N)+1
- CLK  input  1  clock, all state on rising edge
- nRST  input  1  asynchronous reset, active low
- DSI  input  1  pixel-load strobe from upstream; one pixel presented on DI per high cycle
- BYP  output  1  to MED.BYP; 1 = tail register takes chain value (shift/rotate), 0 = tail register keeps MAX (compare)
- DSO  output  1  one-cycle pulse: MED.DO holds the median of the last N loaded pixels
- BUSY  output  1  high while the compare/rotate schedule runs; DSI ignored while high

## Operation
- Moore FSM; BYP, DSO and BUSY decode from registered state only.
- States:
  - IDLE: BYP=1, DSO=0, BUSY=0.
  - LOAD: BYP=1.
  - CMP: BYP=0, BUSY=1.
  - ROT: BYP=1, BUSY=1.
  - DONE: BYP=1, DSO=1, BUSY=0.
- Counters: load count L, pass index P (0..(N-1)/2), step count S.
- IDLE/DONE with DSI=1: L:=1, go LOAD. DONE with DSI=0: go IDLE.
- LOAD: each DSI=1 cycle increments L; DSI=0 cycles hold L (gaps allowed, BYP stays 1).
  - After the N-th DSI-high cycle: P:=0, go CMP.
- CMP pass P lasts N-1-P cycles.
  - On exit, P=(N-1)/2: go DONE.
  - Otherwise: go ROT.
- ROT lasts P+1 cycles, then P:=P+1, go CMP.
- DSI during CMP/ROT has no effect on the schedule. Upstream must not assert it there: MED would load DI.
- Total schedule length for N=9: compare 8+7+6+5+4=30 cycles, rotate 1+2+3+4=10 cycles.

## Timing
- Reset (nRST=0, any time, including mid-schedule): state IDLE, counters 0.
  - Output values during reset: BYP=1, DSO=0, BUSY=0.
  - After reset release, the first DSI-high cycle starts a fresh load. Partial datapath contents are overwritten by the N new pixels.
- Cycle numbering: n=0 is the first DSI-high cycle; DSI is high continuously for N cycles; N=9.
  - n=0..8: BYP=1 (load).
  - n=9..16: BYP=0.
  - n=17: BYP=1.
  - n=18..24: BYP=0.
  - n=25..26: BYP=1.
  - n=27..32: BYP=0.
  - n=33..35: BYP=1.
  - n=36..40: BYP=0.
  - n=41..44: BYP=1.
  - n=45..48: BYP=0.
  - n=49: DSO=1, BYP=1.
  - BUSY=1 exactly for n=9..48.
- Latency from first load cycle to DSO = 49 cycles for N=9. In general it is N + Σ_{p=0}^{(N-1)/2}(N-1-p) + Σ_{p=0}^{(N-3)/2}(p+1).
- Load gaps of k cycles shift every later event by k.
- Back-to-back frames: DSI=1 in cycle 49 counts as load cycle 0 of the next frame. The next DSO then falls at cycle 98. DO at cycle 49 is still the median.
- DSO never asserts for fewer than N loaded pixels.

## Test plan
- Reset then 9 continuous DSI cycles with DI=9,1,8,2,7,3,6,4,5 through MED → BYP pattern exactly as in Timing; DSO single pulse at n=49 with DO=5; BUSY high n=9..48.
- DSI high 4 cycles, low 3, high 5 → CMP starts one cycle after the 9th high cycle (absolute n=12); DSO at n=52.
- Back-to-back frames, DSI high n=0..8 and n=49..57, pixels {0..8} then {200,10,…} → DSO at n=49 (DO=4) and n=98 (DO=median of frame 2); no glitch on BYP at the frame boundary.
- DSI forced high during n=20..22 (checker masks datapath) → BYP/DSO/BUSY sequence unchanged; DSO still at n=49.
- nRST pulsed low at n=30 → BYP=1, DSO=0, BUSY=0 immediately (asynchronous); no DSO until a new 9-cycle load completes, then DSO 49 cycles after its first DSI cycle.
- number=3 build, DI=3,1,2 → BYP: load n=0..2 =1, n=3..4 =0, n=5 =1, n=6 =0; DSO at n=7, DO=2.
